ram_ctrl_param: RTL and testbench

Parametrised single-port word RAM with a ready/valid request interface, a registered read port and a built-in sequential clear engine. It generalises the fixed 16-bit × 8/64-word RAM stacks to arbitrary word width and power-of-two depth. It adds three things the existing stacks lack: an asynchronous reset, an explicit one-cycle read-response handshake, and a whole-array zero-fill operation. It serves as the data/scratch memory behind the register file and datapath blocks.

---
 rtl/ram_ctrl_param.sv | 99 +++++++++
 tb/tb_ram_ctrl_param.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl_param.sv
// Single-port WIDTH x 2**ADDR_BITS RAM: writes land at the accepting edge, reads return one cycle later with a valid pulse.
// ready drops for DEPTH cycles while the clear engine zero-fills the array; requests seen while not ready are dropped.
module ram_ctrl_param #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 req,
  input  logic                 write,
  input  logic [ADDR_BITS-1:0] add,
  input  logic [WIDTH-1:0]     in,
  input  logic                 clear,
  output logic                 ready,
  output logic                 valid,
  output logic [WIDTH-1:0]     out,
  output logic                 clear_done
);

  localparam int                   DEPTH     = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     mem_q [DEPTH];

  logic accept;
  logic do_clear;
  logic do_wr;
  logic do_rd;

  // clear wins over a same-cycle request; the request is simply lost
  assign accept   = en & (state_q == S_IDLE);
  assign do_clear = accept & clear;
  assign do_wr    = accept & req & write & ~clear;
  assign do_rd    = accept & req & ~write & ~clear;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    out_d   = out_q;
    valid_d = do_rd;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (do_clear) begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
      if (do_rd) begin
        out_d = mem_q[add];
      end
    end else begin
      ptr_d = ptr_q + ADDR_BITS'(1);
      if (ptr_q == LAST_ADDR) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Array has no reset: an aborted fill leaves the untouched words as they were
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem_q[ptr_q] <= '0;
    end else if (do_wr) begin
      mem_q[add] <= in;
    end
  end

  assign ready      = (state_q == S_IDLE);
  assign valid      = valid_q;
  assign out        = out_q;
  assign clear_done = done_q;

endmodule

// File: tb/tb_ram_ctrl_param.sv
// Bench for ram_ctrl_param: three instances (16x64, 8x8, 32x2) share request lines, each gated by its own enable;
// read expectations come from per-instance model arrays and are queued, then checked when valid appears.
module tb_ram_ctrl_param;

  logic        clk;
  logic        rst_n;
  logic [2:0]  en_v;
  logic        req;
  logic        write;
  logic [5:0]  add;
  logic [31:0] din;
  logic        clear;

  logic        rdy0, rdy1, rdy2;
  logic        vld0, vld1, vld2;
  logic        done0, done1, done2;
  logic [15:0] out0;
  logic [7:0]  out1;
  logic [31:0] out2;

  int checks   = 0;
  int failures = 0;

  logic [2:0]  msk;
  logic [15:0] m0 [64];
  logic [7:0]  m1 [8];
  logic [31:0] m2 [2];
  logic [15:0] q0 [$];
  logic [7:0]  q1 [$];
  logic [31:0] q2 [$];
  logic [15:0] e0;
  logic [7:0]  e1;
  logic [31:0] e2;

  ram_ctrl_param #(.WIDTH(16), .ADDR_BITS(6)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en_v[0]), .req(req), .write(write), .add(add),
    .in(din[15:0]), .clear(clear), .ready(rdy0), .valid(vld0), .out(out0), .clear_done(done0)
  );

  ram_ctrl_param #(.WIDTH(8), .ADDR_BITS(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en_v[1]), .req(req), .write(write), .add(add[2:0]),
    .in(din[7:0]), .clear(clear), .ready(rdy1), .valid(vld1), .out(out1), .clear_done(done1)
  );

  ram_ctrl_param #(.WIDTH(32), .ADDR_BITS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en_v[2]), .req(req), .write(write), .add(add[0]),
    .in(din), .clear(clear), .ready(rdy2), .valid(vld2), .out(out2), .clear_done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && vld0 === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL rd0_unexpected_valid got out=%h expected no valid", out0);
      end else begin
        e0 = q0.pop_front();
        if (out0 !== e0) begin
          failures++;
          $display("FAIL rd0_data got %h expected %h", out0, e0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && vld1 === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL rd1_unexpected_valid got out=%h expected no valid", out1);
      end else begin
        e1 = q1.pop_front();
        if (out1 !== e1) begin
          failures++;
          $display("FAIL rd1_data got %h expected %h", out1, e1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && vld2 === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        failures++;
        $display("FAIL rd2_unexpected_valid got out=%h expected no valid", out2);
      end else begin
        e2 = q2.pop_front();
        if (out2 !== e2) begin
          failures++;
          $display("FAIL rd2_data got %h expected %h", out2, e2);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy_of(input int idx);
    return (idx == 0) ? rdy0 : (idx == 1) ? rdy1 : rdy2;
  endfunction

  function automatic logic done_of(input int idx);
    return (idx == 0) ? done0 : (idx == 1) ? done1 : done2;
  endfunction

  task automatic wr(input int a, input logic [31:0] d);
    en_v = msk; req = 1'b1; write = 1'b1; add = 6'(a); din = d;
    if (msk[0]) m0[a % 64] = d[15:0];
    if (msk[1]) m1[a % 8]  = d[7:0];
    if (msk[2]) m2[a % 2]  = d;
    step();
    req = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input int a);
    en_v = msk; req = 1'b1; write = 1'b0; add = 6'(a);
    if (msk[0]) q0.push_back(m0[a % 64]);
    if (msk[1]) q1.push_back(m1[a % 8]);
    if (msk[2]) q2.push_back(m2[a % 2]);
    step();
    req = 1'b0;
  endtask

  task automatic check_drained(input string name);
    req = 1'b0;
    step();
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      failures++;
      $display("FAIL %s_pending got %0d outstanding reads expected 0", name, q0.size() + q1.size() + q2.size());
      q0.delete(); q1.delete(); q2.delete();
    end
  endtask

  // Starts a clear on one instance, optionally with a read request held high throughout.
  task automatic do_clear(input int idx, input int depth, input bit rd_during);
    int cnt;
    msk = 3'(1 << idx);
    en_v = msk; clear = 1'b1; req = rd_during; write = 1'b0; add = 6'd3;
    step();
    clear = 1'b0;
    cnt = 0;
    while (rdy_of(idx) !== 1'b1 && cnt < 200) begin
      cnt++;
      step();
    end
    req = 1'b0;
    checks++;
    if (cnt != depth) begin
      failures++;
      $display("FAIL clear%0d_busy_cycles got %0d expected %0d", idx, cnt, depth);
    end
    checks++;
    if (done_of(idx) !== 1'b1) begin
      failures++;
      $display("FAIL clear%0d_done_pulse got %b expected 1", idx, done_of(idx));
    end
    step();
    checks++;
    if (done_of(idx) !== 1'b0) begin
      failures++;
      $display("FAIL clear%0d_done_single got %b expected 0", idx, done_of(idx));
    end
    for (int i = 0; i < depth; i++) begin
      if (idx == 0) m0[i] = '0;
      if (idx == 1) m1[i] = '0;
      if (idx == 2) m2[i] = '0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_v = '0; req = 1'b0; write = 1'b0; add = '0; din = '0; clear = 1'b0; msk = 3'b001;
    repeat (2) step();
    checks++;
    if (rdy0 !== 1'b1 || vld0 !== 1'b0 || out0 !== 16'h0 || done0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b out=%h done=%b expected 1 0 0000 0", rdy0, vld0, out0, done0);
    end
    checks++;
    if (rdy1 !== 1'b1 || rdy2 !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_sweep got %b%b expected 11", rdy1, rdy2);
    end
    #2 rst_n = 1'b1;
    step();
    // Assert reset mid-cycle while a read's valid pulse is on the outputs
    wr(12, 32'h0000_C3C3);
    rd(12);
    req = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rdy0 !== 1'b1 || vld0 !== 1'b0 || out0 !== 16'h0 || done0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got rdy=%b vld=%b out=%h done=%b expected 1 0 0000 0", rdy0, vld0, out0, done0);
    end
    q0.delete();
    req = 1'b0;
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    msk = 3'b001;
    wr(5, 32'h0000_A5A5);
    wr(63, 32'h0000_1234);
    rd(5);
    rd(63);
    check_drained("write_read");
  endtask

  task automatic test_write_then_read();
    msk = 3'b001;
    wr(0, 32'h0000_BEEF);
    rd(0);
    check_drained("write_then_read");
  endtask

  task automatic test_clear();
    msk = 3'b001;
    for (int i = 0; i < 64; i++) wr(i, 32'h0000_FFFF);
    do_clear(0, 64, 1'b1);
    msk = 3'b001;
    for (int i = 0; i < 64; i++) rd(i);
    check_drained("clear");
  endtask

  task automatic test_enable_gating();
    msk = 3'b001;
    wr(9, 32'h0000_1111);
    en_v = 3'b000; req = 1'b1; write = 1'b1; add = 6'd9; din = 32'h0000_5555;
    step();
    write = 1'b0;
    step();
    req = 1'b0;
    rd(9);
    check_drained("enable_gating");
  endtask

  task automatic test_reset_mid_clear();
    msk = 3'b001;
    for (int i = 0; i < 64; i++) wr(i, 32'h0000_FFFF);
    en_v = msk; clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (rdy0 !== 1'b1 || done0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_clear_ready got rdy=%b done=%b expected 1 0", rdy0, done0);
    end
    #1 rst_n = 1'b1;
    step();
    for (int i = 0; i < 10; i++) m0[i] = '0;
    for (int i = 0; i < 64; i++) rd(i);
    check_drained("reset_mid_clear");
  endtask

  task automatic test_sweep();
    msk = 3'b010;
    wr(5, 32'h0000_00A5);
    wr(7, 32'h0000_0012);
    rd(5);
    rd(7);
    check_drained("sweep8_rw");
    for (int i = 0; i < 8; i++) wr(i, 32'h0000_00FF);
    do_clear(1, 8, 1'b0);
    for (int i = 0; i < 8; i++) rd(i);
    check_drained("sweep8_clear");

    msk = 3'b100;
    wr(0, 32'hDEAD_BEEF);
    wr(1, 32'h1234_5678);
    rd(0);
    rd(1);
    rd(0);
    check_drained("sweep32_rw");
    for (int i = 0; i < 2; i++) wr(i, 32'hFFFF_FFFF);
    do_clear(2, 2, 1'b1);
    for (int i = 0; i < 2; i++) rd(i);
    check_drained("sweep32_clear");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_then_read();
    test_clear();
    test_enable_gating();
    test_reset_mid_clear();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
